line_clear_engine: RTL and testbench

//   Post-landing stage of the game datapath. When the game FSM merges a landed

---
 rtl/line_clear_engine.sv | 160 ++++++++++++++++
 tb/tb_line_clear_engine.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/line_clear_engine.sv
// Line-clear engine: scans the stored grid bottom-up, removes full rows by shifting
// the rows above down, and reports the compacted grid, lines cleared and a running score.
// Optional top-out detection is enabled by defining LINE_CLEAR_TOPOUT_EN.
// Grid packing: row r occupies bits [r*COLS +: COLS]; row 0 is the top (spawn) row.
module line_clear_engine #(
  parameter int ROWS    = 22,
  parameter int COLS    = 10,
  parameter int SCORE_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ROWS*COLS-1:0]   grid_i,
  output logic                   busy,
  output logic                   done,
  output logic [ROWS*COLS-1:0]   grid_o,
  output logic [2:0]             lines_o,
  output logic [SCORE_W-1:0]     score_o,
  output logic                   topout_o
);

  localparam int RW = $clog2(ROWS);
  localparam int G  = ROWS * COLS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [G-1:0]       work_q, work_d;
  logic [G-1:0]       grid_q, grid_d;
  logic [RW-1:0]      r_q, r_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [2:0]         lines_q, lines_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               row_full;
  logic               start_ok;

  function automatic logic [2:0] sat7_inc(input logic [2:0] c);
    return (c == 3'd7) ? c : c + 3'd1;
  endfunction

  function automatic logic [3:0] pts(input logic [2:0] c);
    case (c)
      3'd0:    return 4'd0;
      3'd1:    return 4'd1;
      3'd2:    return 4'd3;
      3'd3:    return 4'd5;
      default: return 4'd8;
    endcase
  endfunction

  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] s,
                                                 input logic [3:0] p);
    logic [SCORE_W:0] sum;
    sum = {1'b0, s} + {{(SCORE_W-3){1'b0}}, p};
    return sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
  endfunction

  assign row_full = &work_q[r_q*COLS +: COLS];

`ifdef LINE_CLEAR_TOPOUT_EN
  logic top_q, top_d;
  assign start_ok = start & ~top_q;
  assign topout_o = top_q;
`else
  assign start_ok = start;
  assign topout_o = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    grid_d  = grid_q;
    lines_d = lines_q;
    score_d = score_q;
`ifdef LINE_CLEAR_TOPOUT_EN
    top_d   = top_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          work_d  = grid_i;
          r_d     = RW'(ROWS - 1);
          cnt_d   = 3'd0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (row_full) begin
          state_d = SHIFT;
        end else if (r_q != '0) begin
          r_d = r_q - 1'b1;
        end else begin
          // Results are committed on entry to DONE so they are visible with the done pulse.
          state_d = DONE;
          grid_d  = work_q;
          lines_d = cnt_q;
          score_d = sat_add(score_q, pts(cnt_q));
`ifdef LINE_CLEAR_TOPOUT_EN
          top_d   = top_q | (|work_q[0 +: COLS]) | (|work_q[COLS +: COLS]);
`endif
        end
      end
      SHIFT: begin
        // Rows at or above r drop by one; r stays so the refilled row is rescanned.
        for (int k = 1; k < ROWS; k++) begin
          if (RW'(k) <= r_q) work_d[k*COLS +: COLS] = work_q[(k-1)*COLS +: COLS];
        end
        work_d[0 +: COLS] = '0;
        cnt_d   = sat7_inc(cnt_q);
        state_d = SCAN;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      work_q  <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      grid_q  <= '0;
      lines_q <= '0;
      score_q <= '0;
`ifdef LINE_CLEAR_TOPOUT_EN
      top_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      grid_q  <= grid_d;
      lines_q <= lines_d;
      score_q <= score_d;
`ifdef LINE_CLEAR_TOPOUT_EN
      top_q   <= top_d;
`endif
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign grid_o  = grid_q;
  assign lines_o = lines_q;
  assign score_o = score_q;

endmodule

// File: tb/tb_line_clear_engine.sv
// Scoreboard bench for line_clear_engine: a driver pushes expected results computed by a
// row-filtering reference model; a monitor pops and compares on every done pulse.
module tb_line_clear_engine;

  localparam int ROWS = 22;
  localparam int COLS = 10;
  localparam int SW   = 6;
  localparam int G    = ROWS * COLS;
  localparam int MAXS = (1 << SW) - 1;

  logic          clk;
  logic          reset;
  logic          start;
  logic [G-1:0]  grid_i;
  logic          busy;
  logic          done;
  logic [G-1:0]  grid_o;
  logic [2:0]    lines_o;
  logic [SW-1:0] score_o;
  logic          topout_o;

  line_clear_engine #(.ROWS(ROWS), .COLS(COLS), .SCORE_W(SW)) dut (
    .clk(clk), .reset(reset), .start(start), .grid_i(grid_i),
    .busy(busy), .done(done), .grid_o(grid_o), .lines_o(lines_o),
    .score_o(score_o), .topout_o(topout_o)
  );

  typedef struct {
    logic [G-1:0]  grid;
    logic [2:0]    lines;
    logic [SW-1:0] score;
    int            done_cyc;
    logic          topout;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   model_score = 0;
  bit   model_top = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Reference: keep non-full rows in bottom-up order and pack them against the floor.
  function automatic void model(input logic [G-1:0] g, output logic [G-1:0] o, output int k);
    int dst;
    logic [COLS-1:0] row;
    o = '0;
    k = 0;
    dst = ROWS - 1;
    for (int r = ROWS - 1; r >= 0; r--) begin
      row = g[r*COLS +: COLS];
      if (&row) k++;
      else begin
        o[dst*COLS +: COLS] = row;
        dst--;
      end
    end
  endfunction

  function automatic logic [G-1:0] rand_grid();
    logic [G-1:0] g;
    int sel;
    g = '0;
    for (int r = 4; r < ROWS; r++) begin
      sel = int'($urandom_range(0, 3));
      if (sel == 0) g[r*COLS +: COLS] = '1;
      else if (sel >= 2) g[r*COLS +: COLS] = COLS'($urandom);
    end
    return g;
  endfunction

  // Monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && done === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 required=0 at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("grid_o", 256'(grid_o), 256'(e.grid));
        chk("lines_o", 256'(lines_o), 256'(e.lines));
        chk("score_o", 256'(score_o), 256'(e.score));
        chk("topout_o", 256'(topout_o), 256'(e.topout));
        chk("busy_at_done", 256'(busy), 256'(1'b1));
        chk("done_latency", 256'(cyc), 256'(e.done_cyc));
      end
    end
  end

  // Called at a negedge with the DUT idle; leaves at the negedge of the cycle after done.
  task automatic issue(input logic [G-1:0] g, input bit extra_start);
    logic [G-1:0] o;
    int k, p, n;
    int pts_tab[5];
    exp_t e;
    pts_tab = '{0, 1, 3, 5, 8};
    if (model_top) begin
      start = 1'b1; grid_i = g;
      @(negedge clk);
      start = 1'b0;
      repeat (40) @(negedge clk);
      chk("ignored_start_busy", 256'(busy), 256'(1'b0));
      return;
    end
    model(g, o, k);
    p = pts_tab[(k > 4) ? 4 : k];
    model_score = (model_score + p > MAXS) ? MAXS : model_score + p;
`ifdef LINE_CLEAR_TOPOUT_EN
    model_top = model_top | (|o[0 +: COLS]) | (|o[COLS +: COLS]);
`endif
    e.grid = o;
    e.lines = 3'((k > 7) ? 7 : k);
    e.score = SW'(model_score);
    e.done_cyc = cyc + 1 + ROWS + 2 * k;
    e.topout = model_top;
    q.push_back(e);
    start = 1'b1; grid_i = g;
    @(negedge clk);
    start = 1'b0;
    if (extra_start) begin
      repeat (3) @(negedge clk);
      start = 1'b1; grid_i = rand_grid();
      @(negedge clk);
      start = 1'b0;
    end
    n = 0;
    while (done !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=0 required=1");
    end
    @(negedge clk);
    chk("busy_after_done", 256'(busy), 256'(1'b0));
    chk("done_pulse_width", 256'(done), 256'(1'b0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [G-1:0] g;
    reset = 1'b1; start = 1'b0; grid_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 256'(busy), 256'(1'b0));
    chk("rst_done", 256'(done), 256'(1'b0));
    chk("rst_grid", 256'(grid_o), 256'(0));
    chk("rst_lines", 256'(lines_o), 256'(0));
    chk("rst_score", 256'(score_o), 256'(0));
    chk("rst_topout", 256'(topout_o), 256'(0));
    reset = 1'b0;
    @(negedge clk);

    // T1 empty grid
    issue('0, 1'b0);
    // T2 single clear with a residue row above
    g = '0; g[21*COLS +: COLS] = '1; g[20*COLS +: COLS] = 10'h001;
    issue(g, 1'b0);
    // T3 four clears
    g = '0;
    for (int r = 18; r < 22; r++) g[r*COLS +: COLS] = '1;
    g[17*COLS +: COLS] = 10'h3F0;
    issue(g, 1'b0);
    // T4 split clears plus a start while busy
    g = '0; g[21*COLS +: COLS] = '1; g[19*COLS +: COLS] = '1; g[20*COLS +: COLS] = 10'h155;
    issue(g, 1'b1);
    repeat (60) @(negedge clk);
    // All-full grid: lines saturate, grid empties
    issue('1, 1'b0);

    // T5 reset during SHIFT
    g = '0; g[21*COLS +: COLS] = '1; g[20*COLS +: COLS] = '1;
    start = 1'b1; grid_i = g;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrun_rst_busy", 256'(busy), 256'(1'b0));
    chk("midrun_rst_done", 256'(done), 256'(1'b0));
    chk("midrun_rst_grid", 256'(grid_o), 256'(0));
    chk("midrun_rst_score", 256'(score_o), 256'(0));
    q.delete();
    model_score = 0;
    model_top = 0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    g = '0; g[21*COLS +: COLS] = '1; g[20*COLS +: COLS] = 10'h001;
    issue(g, 1'b0);

    // Randomized runs; score saturates along the way
    for (int i = 0; i < 25; i++) issue(rand_grid(), ($urandom_range(0, 3) == 0));

    // T6 spawn-row occupancy, then a start that top-out must block (macro build only)
    g = '0; g[1*COLS +: COLS] = 10'h010;
    issue(g, 1'b0);
    issue(rand_grid(), 1'b0);

    repeat (50) @(negedge clk);
    chk("outstanding_expectations", 256'(q.size()), 256'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
